mem_arbiter: RTL and testbench

Single-port access controller that sits directly upstream of the 128-word × 32-bit RAM. It arbitrates between the instruction-fetch port and the data-memory (load/store) port of the CPU pipeline. It converts 32-bit byte addresses to 7-bit word indices and sequences the RAM's level-sensitive write enable and bidirectional data bus safely. Each requester gets a registered one-cycle acknowledge and registered read data.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arbiter RAM access
// controller.
//   state_t  : arbiter FSM states
//   owner_t  : which requester currently owns the RAM
//   WORD_LSB : byte-address bit where the RAM word index starts
//   ADDR_W_DFLT / DATA_W_DFLT : default RAM geometry (128 x 32)
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DFLT = 7;
  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned WORD_LSB    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_HOLD,
    ST_ACK
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port access controller in front of the 128-word RAM.
// Arbitrates instruction fetch against data load/store (data wins), turns
// byte addresses into word indices, and sequences the RAM's level-sensitive
// write enable and bidirectional bus.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   if_req/if_addr          : fetch request and byte address
//   if_ack/if_rdata         : one-cycle ack with registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata : data request (we=1 store)
//   dm_ack/dm_rdata/dm_err  : one-cycle ack, registered load data, misalign flag
//   ram_addr/ram_wre        : registered RAM word address and write enable
//   ram_data                : RAM bus, driven only in WR and WR_HOLD
//
// Build option: define MEM_ARB_ALIGN_CHECK_EN to reject misaligned data
// accesses (no RAM cycle, dm_err with dm_ack, dm_rdata cleared).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wre,
  inout  logic [DATA_W-1:0] ram_data
);

  state_t            state, state_next;
  owner_t            owner, owner_next;
  logic              grant;
  logic              err_grant;
  logic              misaligned;
  logic [DATA_W-1:0] wdata_q;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misaligned = (dm_addr[WORD_LSB-1:0] != '0);
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:WORD_LSB+ADDR_W], if_addr[WORD_LSB-1:0],
                              dm_addr[31:WORD_LSB+ADDR_W]};
`else
  assign misaligned = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:WORD_LSB+ADDR_W], if_addr[WORD_LSB-1:0],
                              dm_addr[31:WORD_LSB+ADDR_W], dm_addr[WORD_LSB-1:0]};
`endif

  // The store/load decision is taken at grant time and carried by the
  // state itself, so no separate latched copy of dm_we is needed.
  always_comb begin
    state_next = state;
    owner_next = owner;
    grant      = 1'b0;
    err_grant  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dm_req) begin
          grant      = 1'b1;
          owner_next = OWN_DATA;
          if (misaligned) begin
            err_grant  = 1'b1;
            state_next = ST_ACK;
          end else begin
            state_next = dm_we ? ST_WR : ST_RD;
          end
        end else if (if_req) begin
          grant      = 1'b1;
          owner_next = OWN_FETCH;
          state_next = ST_RD;
        end
      end
      ST_RD:      state_next = ST_ACK;
      ST_WR:      state_next = ST_WR_HOLD;
      ST_WR_HOLD: state_next = ST_ACK;
      ST_ACK:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Outputs are registered from the next-state decode so that ack, write
  // enable and error line up exactly with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner    <= OWN_FETCH;
      ram_addr <= '0;
      ram_wre  <= 1'b0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      dm_err   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      wdata_q  <= '0;
    end else begin
      if (grant) begin
        owner <= owner_next;
        if (owner_next == OWN_DATA) begin
          ram_addr <= dm_addr[WORD_LSB +: ADDR_W];
          wdata_q  <= dm_wdata;
        end else begin
          ram_addr <= if_addr[WORD_LSB +: ADDR_W];
        end
      end
      ram_wre <= (state_next == ST_WR);
      if_ack  <= (state_next == ST_ACK) && (owner_next == OWN_FETCH);
      dm_ack  <= (state_next == ST_ACK) && (owner_next == OWN_DATA);
      dm_err  <= err_grant;
      if (state == ST_RD) begin
        if (owner == OWN_FETCH) if_rdata <= ram_data;
        else                    dm_rdata <= ram_data;
      end
      if (err_grant) dm_rdata <= '0;
    end
  end

  // Bus stays driven through WR_HOLD so data is stable after ram_wre falls.
  assign ram_data = (state == ST_WR || state == ST_WR_HOLD) ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a 128-word RAM (word k = BCD of k).
// Table vectors, hand sequences (simultaneous requests, reset during WR) and
// random transactions checked against a transaction-level memory model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, dm_err, ram_wre;
  logic [31:0] if_rdata, dm_rdata;
  logic [6:0]  ram_addr;
  wire  [31:0] ram_data;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_data(ram_data)
  );

  // RAM: asynchronous read, write while ram_wre is high. It only drives the
  // bus when no write is active or just finished; otherwise the pullup shows
  // an undriven bus as all ones.
  logic [31:0] mem [128];
  logic        wre_d = 1'b0;
  logic        preload;
  logic        ram_oe;

  function automatic logic [31:0] bcd(int unsigned k);
    return 32'((k / 100) * 256 + ((k / 10) % 10) * 16 + (k % 10));
  endfunction

  always @(posedge clock) begin
    wre_d <= ram_wre;
    if (preload) begin
      for (int k = 0; k < 128; k++) mem[k] <= bcd(k);
    end else if (ram_wre) begin
      mem[ram_addr] <= ram_data;
    end
  end

  assign ram_oe = !ram_wre && !wre_d;
  assign ram_data = ram_oe ? mem[ram_addr] : 'z;
  pullup (ram_data);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory contents and the last value each port returned.
  logic [31:0] ref_mem [128];
  logic [31:0] exp_if_rd, exp_dm_rd;

  // Results of one run
  int          f_lat, d_lat, wre_cnt, addr_bad, data_bad;
  logic [31:0] f_rd, d_rd;
  logic [6:0]  addr_at1;
  bit          d_err, both_ack, prev_wre;

  // Entered just after a posedge with the DUT idle; returns in the next idle
  // cycle. Latency c means the ack was seen after the c-th edge counted from
  // the grant edge (c = 1).
  task automatic run(input bit f_en, input logic [31:0] f_addr, input bit d_en,
                     input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata);
    f_lat = -1; d_lat = -1; wre_cnt = 0; addr_bad = 0; data_bad = 0;
    both_ack = 0; prev_wre = 0; d_err = 0; f_rd = '0; d_rd = '0;
    if_req = f_en; if_addr = f_addr;
    dm_req = d_en; dm_we = d_we; dm_addr = d_addr; dm_wdata = d_wdata;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); #1;
      if (c == 1) addr_at1 = ram_addr;
      if (ram_wre) begin
        wre_cnt++;
        if (ram_data !== d_wdata) data_bad++;
        if (ram_addr != d_addr[8:2]) addr_bad++;
      end else if (prev_wre && ram_addr != d_addr[8:2]) begin
        addr_bad++;
      end
      prev_wre = ram_wre;
      if (if_ack && dm_ack) both_ack = 1;
      if (dm_ack && d_lat < 0) begin
        d_lat = c; d_rd = dm_rdata; d_err = dm_err; dm_req = 0;
      end
      if (if_ack && f_lat < 0) begin
        f_lat = c; f_rd = if_rdata; if_req = 0;
      end
      if ((!f_en || f_lat > 0) && (!d_en || d_lat > 0)) break;
    end
    if_req = 0; dm_req = 0;
    @(posedge clock); #1;
  endtask

  task automatic expect_run(input bit f_en, input logic [31:0] f_addr, input bit d_en,
                            input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata);
    bit         mis;
    int         e_dlat;
    logic [6:0] dw, fw;
    dw = d_addr[8:2];
    fw = f_addr[8:2];
`ifdef MEM_ARB_ALIGN_CHECK_EN
    mis = d_en && (d_addr[1:0] != 2'b00);
`else
    mis = 0;
`endif
    e_dlat = mis ? 1 : (d_we ? 3 : 2);
    run(f_en, f_addr, d_en, d_we, d_addr, d_wdata);
    if (d_en) begin
      if (mis)       exp_dm_rd = '0;
      else if (d_we) ref_mem[dw] = d_wdata;
      else           exp_dm_rd = ref_mem[dw];
      chk("dm_latency", d_lat, e_dlat);
      chk("dm_err", 32'(d_err), 32'(mis));
      chk("dm_rdata_at_ack", d_rd, exp_dm_rd);
      chk("ram_wre_cycles", wre_cnt, (d_we && !mis) ? 1 : 0);
      if (!mis) chk("ram_addr_grant", 32'(addr_at1), 32'(dw));
    end else begin
      chk("ram_wre_cycles", wre_cnt, 0);
      chk("ram_addr_grant", 32'(addr_at1), 32'(fw));
    end
    if (f_en) begin
      exp_if_rd = ref_mem[fw];
      chk("if_latency", f_lat, d_en ? e_dlat + 3 : 2);
      chk("if_rdata_at_ack", f_rd, exp_if_rd);
    end
    if (wre_cnt > 0) begin
      chk("ram_addr_around_wre", addr_bad, 0);
      chk("ram_data_during_wre", data_bad, 0);
    end
    if (f_en && d_en) chk("acks_overlap", 32'(both_ack), 0);
    chk("if_rdata_hold", if_rdata, exp_if_rd);
    chk("dm_rdata_hold", dm_rdata, exp_dm_rd);
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, w;
    int          kind;
    logic [31:0] rd;
    int          lat;

    tbl[0] = '{0, 0, 32'h0000_0014, 32'h0, 1, 32'h0000_0005, 2, 0};
`ifdef MEM_ARB_ALIGN_CHECK_EN
    tbl[1] = '{1, 0, 32'h0000_0031, 32'h0, 1, 32'h0000_0000, 1, 1};
`else
    tbl[1] = '{1, 0, 32'h0000_0031, 32'h0, 1, 32'h0000_0012, 2, 0};
`endif
    tbl[2] = '{1, 1, 32'h0000_0030, 32'hDEAD_BEEF, 0, 32'h0, 3, 0};
    tbl[3] = '{1, 0, 32'h0000_0030, 32'h0, 1, 32'hDEAD_BEEF, 2, 0};
    tbl[4] = '{1, 0, 32'h0000_0204, 32'h0, 1, 32'h0000_0001, 2, 0};
    tbl[5] = '{0, 0, 32'h0000_0030, 32'h0, 1, 32'hDEAD_BEEF, 2, 0};
    tbl[6] = '{0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h0000_0127, 2, 0};
    tbl[7] = '{1, 0, 32'h0000_0008, 32'h0, 1, 32'h0000_0002, 2, 0};

    for (int k = 0; k < 128; k++) ref_mem[k] = bcd(k);
    exp_if_rd = '0; exp_dm_rd = '0;

    reset = 1; preload = 1;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    preload = 0;
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_dm_ack", 32'(dm_ack), 0);
    chk("rst_dm_err", 32'(dm_err), 0);
    chk("rst_ram_wre", 32'(ram_wre), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    reset = 0;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      expect_run(!tbl[i].dm, tbl[i].addr, tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      rd  = tbl[i].dm ? d_rd : f_rd;
      lat = tbl[i].dm ? d_lat : f_lat;
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      if (tbl[i].dm) chk($sformatf("tbl%0d_err", i), 32'(d_err), 32'(tbl[i].exp_err));
    end

    // Simultaneous fetch (word 7) and load 0x08: data first, fetch 3 later.
    expect_run(1, 32'h0000_001C, 1, 0, 32'h0000_0008, 32'h0);
    chk("dual_dm_latency", d_lat, 2);
    chk("dual_dm_rdata", d_rd, 32'h0000_0002);
    chk("dual_if_latency", f_lat, 5);
    chk("dual_if_rdata", f_rd, 32'h0000_0007);

    // Reset in the WR cycle of a store to word 16.
    dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0040; dm_wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    chk("rstwr_wre_in_wr", 32'(ram_wre), 1);
    reset = 1; dm_req = 0;
    @(posedge clock); #1;
    chk("rstwr_wre_dropped", 32'(ram_wre), 0);
    chk("rstwr_bus_released", ram_data, 32'hFFFF_FFFF);
    chk("rstwr_no_ack", 32'(dm_ack), 0);
    reset = 0;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      if (dm_ack || if_ack || ram_wre) lat++;
    end
    chk("rstwr_quiet_after", lat, 0);
    ref_mem[16] = 32'hCAFE_F00D;
    exp_if_rd = '0; exp_dm_rd = '0;
    expect_run(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0);
    expect_run(0, 32'h0, 1, 0, 32'h0000_0040, 32'h0);

    // Random traffic against the memory model.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      a = $urandom; b = $urandom; w = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      case (kind)
        0:       expect_run(1, a, 0, 0, b, w);
        1:       expect_run(0, a, 1, 0, b, w);
        2:       expect_run(0, a, 1, 1, b, w);
        default: expect_run(1, a, 1, 1'($urandom_range(0, 1)), b, w);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
